hex_entry_ctrl: RTL
===================

# hex_entry_ctrl

Input-side companion to the board's four-digit seven-segment display driver. It debounces four pushbuttons and uses them to edit a four-digit hex value: increment or decrement the selected digit, move the cursor, and commit. Its hex digit and decimal-point outputs drive the display driver directly, so the cursor shows as the lit decimal point. Downstream logic (e.g. memory-controller address/data entry) consumes the committed value on a one-cycle strobe.

## Interface
- DB_COUNT, 1_000_000 — cycles a synchronized button level must stay stable before it is accepted; the default is 20 ms at 50 MHz. Legal range is ≥ 2.
- DB_W, 20 — debounce counter width; must satisfy 2^DB_W ≥ DB_COUNT.

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- btn  in  4  raw pushbuttons, active-high, asynchronous to clk; [0]=inc, [1]=dec, [2]=cursor-left, [3]=commit
- hex3, hex2, hex1, hex0  out  4 each  working digits, to display driver; reset 0
- dp_out  out  4  one-hot cursor position, to display driver dp inputs; reset 4'b0001
- value  out  16  last committed value {hex3,hex2,hex1,hex0}; reset 16'h0000
- commit_stb  out  1  one-cycle pulse when value updates; reset 0
- btn_db  out  4  debounced button levels; reset 0

## Operation
- Each btn bit passes through a 2-flop synchronizer (reset 0), then a debounce FSM.
- Debounce FSM states: ZERO, WAIT_ONE, ONE, WAIT_ZERO. Reset state is ZERO.
  - ZERO: if sync=1, go to WAIT_ONE and load cnt=DB_COUNT-1.
  - WAIT_ONE: if sync=0, return to ZERO. Else if cnt=0, go to ONE and assert tick for 1 cycle. Else cnt-1.
  - ONE: if sync=0, go to WAIT_ZERO and load cnt=DB_COUNT-1.
  - WAIT_ZERO: if sync=1, return to ONE. Else if cnt=0, go to ZERO with no tick. Else cnt-1.
  - btn_db=1 in ONE and WAIT_ZERO.
- Edit logic acts on the registered per-button ticks. When several ticks arrive in the same cycle, priority is commit > cursor > inc > dec; lower-priority ticks in that cycle are discarded.
  - inc: selected digit +1 modulo 16 (F→0).
  - dec: selected digit −1 modulo 16 (0→F).
  - cursor: dp_out rotates left (0001→0010→0100→1000→0001).
  - commit: value ← {hex3..hex0}. commit_stb=1 for the following cycle. Digits and cursor are unchanged.
- Only the digit selected by dp_out is modified; the other digits hold.
- A button held through reset deassertion produces one tick after the normal debounce time, because the synchronizer restarts from 0.

## Timing
- Let edge 0 be the first clk edge that samples raw btn high, with btn held high afterwards.
  - sync output is high after edge 1.
  - FSM enters WAIT_ONE at edge 2.
  - tick and btn_db rise at edge DB_COUNT+2.
- Digit/cursor update or commit_stb assertion occurs at edge DB_COUNT+3: one cycle after the tick.
- Release: btn_db falls DB_COUNT+2 edges after release is first sampled. Release never produces a tick.
- A glitch shorter than DB_COUNT stable cycles produces no tick and no change to btn_db.
- Asserting reset_n low at any time immediately forces every output to its reset value. It also clears all FSMs, counters and synchronizers. Any in-flight debounce is lost.

## Structure
- Shared package holds:
  - debounce state encoding (2-bit enum: ZERO, WAIT_ONE, ONE, WAIT_ZERO);
  - button index constants BTN_INC=0, BTN_DEC=1, BTN_CUR=2, BTN_COMMIT=3;
  - cursor reset constant 4'b0001.
- Sub-module btn_debounce: synchronizer, FSM and counter for one button, with outputs level and tick. It is instantiated 4×.
- hex_entry_ctrl contains the tick-priority and edit/commit registers.

## Test plan
All scenarios use DB_COUNT=4.
- Hold btn[0] high from edge 0 → tick at edge 6. At edge 7, hex0 becomes 1; the other digits stay 0 and dp_out stays 0001. commit_stb stays 0.
- Pulse btn[1] for 3 cycles, then low → no tick and btn_db[1] stays 0. A subsequent clean dec press with hex0=0 → hex0=F.
- Two clean cursor presses, then three inc presses → dp_out=0100 and hex2=3. Then a commit press → value=16'h0300 and commit_stb high for exactly 1 cycle.
- btn[3] and btn[0] rise in the same cycle and are held → only the commit takes effect: value is updated and no digit changes.
- Cursor from 1000 plus a clean cursor press → 0001. Sixteen inc presses on hex1 → hex1 returns to its original value.
- Drive reset_n low during WAIT_ONE with btn held high → all outputs reset, with dp_out=0001. After release, a tick occurs DB_COUNT+2 edges later and hex0 becomes 1.

Source files
------------

// File: rtl/hex_entry_ctrl_pkg.sv
// Shared definitions for the hex entry controller: debounce state encoding,
// button index assignments and the cursor reset position.
package hex_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ZERO      = 2'd0,
    WAIT_ONE  = 2'd1,
    ONE       = 2'd2,
    WAIT_ZERO = 2'd3
  } db_state_e;

  localparam int unsigned BTN_INC    = 0;
  localparam int unsigned BTN_DEC    = 1;
  localparam int unsigned BTN_CUR    = 2;
  localparam int unsigned BTN_COMMIT = 3;

  localparam int unsigned NUM_BTNS   = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;

  localparam logic [3:0] CURSOR_RST = 4'b0001;

endpackage

// File: rtl/hex_entry_ctrl_btn_debounce.sv
// Single-button conditioner: 2-flop synchronizer followed by a debounce FSM.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   btn_async    : raw button level, asynchronous to clk
//   level        : debounced level (high in ONE / WAIT_ZERO)
//   tick         : one-cycle pulse on accepted press (never on release)
module btn_debounce
  import hex_entry_ctrl_pkg::*;
#(
  parameter int unsigned DB_COUNT = 1_000_000,
  parameter int unsigned DB_W     = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_async,
  output logic level,
  output logic tick
);

  localparam logic [DB_W-1:0] CNT_LOAD = DB_W'(DB_COUNT - 1);

  logic [1:0]      sync_q, sync_d;
  db_state_e       state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            level_q, level_d;
  logic            sync_c;

  // State and synchronizer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b00;
      state_q <= ZERO;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
    end
  end

  // Next-state; tick and level are computed from the next state so they
  // change on the same edge as the state itself
  always_comb begin
    sync_d  = {sync_q[0], btn_async};
    sync_c  = sync_q[1];
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (sync_c) begin
          state_d = WAIT_ONE;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT_ONE: begin
        if (!sync_c) begin
          state_d = ZERO;
        end else if (cnt_q == '0) begin
          state_d = ONE;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - DB_W'(1);
        end
      end
      ONE: begin
        if (!sync_c) begin
          state_d = WAIT_ZERO;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT_ZERO: begin
        if (sync_c) begin
          state_d = ONE;
        end else if (cnt_q == '0) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q - DB_W'(1);
        end
      end
      default: state_d = ZERO;
    endcase
    level_d = (state_d == ONE) || (state_d == WAIT_ZERO);
  end

  assign level = level_q;
  assign tick  = tick_q;

endmodule

// File: rtl/hex_entry_ctrl.sv
// Four-digit hex entry: debounced buttons edit the digit under the cursor,
// rotate the cursor, or commit the working digits to value.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   btn[3:0]            : raw buttons {commit, cursor, dec, inc}
//   hex3..hex0          : working digits to the display driver
//   dp_out              : one-hot cursor (display decimal points)
//   value, commit_stb   : committed value and its one-cycle update strobe
//   btn_db              : debounced button levels
module hex_entry_ctrl
  import hex_entry_ctrl_pkg::*;
#(
  parameter int unsigned DB_COUNT = 1_000_000,
  parameter int unsigned DB_W     = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  btn,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [3:0]  dp_out,
  output logic [15:0] value,
  output logic        commit_stb,
  output logic [3:0]  btn_db
);

  logic [NUM_BTNS-1:0] tick_c;
  logic [NUM_BTNS-1:0] level_c;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
    btn_debounce #(
      .DB_COUNT (DB_COUNT),
      .DB_W     (DB_W)
    ) u_db (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_async (btn[g]),
      .level     (level_c[g]),
      .tick      (tick_c[g])
    );
  end

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_q, dig_d;
  logic [3:0]                         dp_q, dp_d;
  logic [15:0]                        value_q, value_d;
  logic                               stb_q, stb_d;

  // Edit/commit registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_q   <= '0;
      dp_q    <= CURSOR_RST;
      value_q <= 16'h0000;
      stb_q   <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      value_q <= value_d;
      stb_q   <= stb_d;
    end
  end

  // One action per cycle: commit > cursor > inc > dec
  always_comb begin
    dig_d   = dig_q;
    dp_d    = dp_q;
    value_d = value_q;
    stb_d   = 1'b0;
    if (tick_c[BTN_COMMIT]) begin
      value_d = dig_q;
      stb_d   = 1'b1;
    end else if (tick_c[BTN_CUR]) begin
      dp_d = {dp_q[2:0], dp_q[3]};
    end else if (tick_c[BTN_INC]) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (dp_q[i]) dig_d[i] = dig_q[i] + 4'd1;
      end
    end else if (tick_c[BTN_DEC]) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (dp_q[i]) dig_d[i] = dig_q[i] - 4'd1;
      end
    end
  end

  assign hex3       = dig_q[3];
  assign hex2       = dig_q[2];
  assign hex1       = dig_q[1];
  assign hex0       = dig_q[0];
  assign dp_out     = dp_q;
  assign value      = value_q;
  assign commit_stb = stb_q;
  assign btn_db     = level_c;

endmodule
